btn_inport: RTL and testbench
=============================

Name: btn_inport

Overview:
- Memory-mapped input-port peripheral for the comp system bus. It receives the asynchronous button/switch lines that drive PORTI/PORTJ.
- Per bit: synchronises, debounces, and captures rising and falling edges into sticky, CPU-clearable latches. Raises irq for enabled events.
- Receive-side counterpart of the button/switch stimulus generation; one instance per input port.

Parameters:
- WIDTH, 32, number of input pins and the bus data width.
- PRESCALE, 16, clk cycles per debounce sample tick (>=1).
- DEB_CYCLES, 4, consecutive differing sample ticks needed to accept a new level (1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- pin  input  WIDTH  raw asynchronous button/switch lines.
- cs  input  1  bus chip select.
- wen  input  1  write enable (qualified by cs).
- addr  input  2  register select.
- din  input  WIDTH  bus write data.
- dout  output  WIDTH  bus read data (combinational from addr).
- value  output  WIDTH  debounced pin levels.
- irq  output  1  registered interrupt request.

Behaviour:
- Reset (async, any time, including mid-debounce):
  - sync stages, value, rise, fall, mask, per-bit counters, prescaler all cleared to 0.
  - irq=0; dout follows addr over the cleared registers.
- Synchroniser: 2 flip-flop stages per bit. s = second stage.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 for one clk when the count equals PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- Debounce, per bit i, evaluated only on tick:
  - If s[i]==value[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEB_CYCLES-1: value[i] <= s[i], cnt[i] <= 0, edge event generated.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEB_CYCLES ticks never changes value; a return to the old level restarts counting.
- Latency: a stable pin change appears on value between 2+(DEB_CYCLES-1)*PRESCALE+1 and 2+DEB_CYCLES*PRESCALE clk cycles after the change.
- Edge latches, set in the same clk as value updates:
  - rise[i] is set when value[i] goes 0->1.
  - fall[i] is set when value[i] goes 1->0.
- Register map:
  - addr 0: read value; writes ignored.
  - addr 1: read rise; write-1-to-clear (rise <= rise & ~din).
  - addr 2: read fall; write-1-to-clear.
  - addr 3: read/write mask; plain write.
- Write is taken on the clk edge where cs&wen=1.
- Set/clear collision: an edge set in the same cycle as a write-1-clear of that bit keeps the bit set (set wins). Clearing other bits is unaffected.
- irq <= |((rise|fall)&mask), registered, so it follows a latch/mask change by 1 clk.
  - irq stays high until all enabled latches are cleared or masked.
  - A mask write to 0 drops irq on the following clk.
- Bits are fully independent; several bits may change value in the same tick.
- cs=0: no state change from the bus; dout is still driven (decode outside).

Test Plan:
- Reset mid-debounce (PRESCALE=4, DEB_CYCLES=3): pin=1 held 6 clk, then reset asserted for 1 clk -> value=0, rise=0, irq=0 immediately. Counters start from 0 afterwards, so value needs a full 3 ticks again.
- Clean press, same parameters: pin[0] 0->1 and held -> value[0]=1 within 11..14 clk. rise reads 0x1, fall 0x0. With mask=0x1, irq=1 exactly one clk after rise sets.
- Glitch rejection: pin[3] high for 2 ticks (8 clk) then low -> value, rise, fall stay 0x0; irq stays 0.
- Release and clear: after the press, pin[0]->0 -> fall=0x1. Write addr1 din=0x1 and addr2 din=0x1 -> both read 0. irq falls one clk after the last clear.
- Collision: pin[1] change timed so the rise set coincides with a write addr1 din=0x2 -> rise[1] reads 1 afterwards. A concurrent clear of rise[0] still clears it.
- Multi-bit and mask: pin=0xF0000001 stable -> value=0xF0000001 and rise=0xF0000001 in the same cycle. With mask=0x0, irq=0; writing mask=0x80000000 -> irq=1 one clk later; writing addr0 leaves value unchanged.

Source files
------------

// File: rtl/btn_inport.sv
// Debounced button/switch input port: two-flop synchroniser, prescaled debounce,
// sticky W1C rise/fall latches and a masked, registered interrupt.
module btn_inport #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PRESCALE   = 16,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin,
    input  logic             cs,
    input  logic             wen,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] value,
    output logic             irq
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    pre_q;
    logic             tick;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] rise_q, rise_d, rise_set, rise_clr;
    logic [WIDTH-1:0] fall_q, fall_d, fall_set, fall_clr;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [3:0]       cnt_q [WIDTH];
    logic [3:0]       cnt_d [WIDTH];
    logic             irq_q;
    logic             wr;

    assign tick = (pre_q == PW'(PRESCALE - 1));
    assign wr   = cs & wen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: a new level must persist for DEB_CYCLES consecutive ticks.
    always_comb begin
        value_d  = value_q;
        rise_set = '0;
        fall_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == value_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == 4'(DEB_CYCLES - 1)) begin
                    value_d[i]  = sync2_q[i];
                    cnt_d[i]    = '0;
                    rise_set[i] = sync2_q[i];
                    fall_set[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Set wins over a simultaneous write-1-to-clear of the same bit.
    always_comb begin
        rise_clr = (wr && addr == 2'd1) ? din : '0;
        fall_clr = (wr && addr == 2'd2) ? din : '0;
        rise_d   = (rise_q & ~rise_clr) | rise_set;
        fall_d   = (fall_q & ~fall_clr) | fall_set;
        mask_d   = (wr && addr == 2'd3) ? din : mask_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            value_q <= value_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            mask_q  <= mask_d;
            irq_q   <= |((rise_q | fall_q) & mask_q);
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        dout = value_q;
        case (addr)
            2'd0: dout = value_q;
            2'd1: dout = rise_q;
            2'd2: dout = fall_q;
            2'd3: dout = mask_q;
        endcase
    end

    assign value = value_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_btn_inport.sv
// Directed bench for btn_inport with PRESCALE=4, DEB_CYCLES=3; expected values hand-derived.
module tb_btn_inport;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pin;
    logic        cs, wen;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] value;
    logic        irq;

    int checks = 0;
    int errors = 0;

    btn_inport #(
        .WIDTH      (32),
        .PRESCALE   (4),
        .DEB_CYCLES (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pin   (pin),
        .cs    (cs),
        .wen   (wen),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .value (value),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs   = 1'b1;
        wen  = 1'b1;
        addr = a;
        din  = d;
        step();
        cs   = 1'b0;
        wen  = 1'b0;
    endtask

    task automatic wait_bit0(input logic lvl, output int n);
        n = 0;
        while (value[0] !== lvl && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int          n;
        int          irq_hi;

        reset = 1'b1;
        pin   = '0;
        cs    = 1'b0;
        wen   = 1'b0;
        addr  = 2'd0;
        din   = '0;
        step();
        step();
        check("rst_value", value, 32'h0);
        rd(2'd1, r); check("rst_rise", r, 32'h0);
        rd(2'd2, r); check("rst_fall", r, 32'h0);
        rd(2'd3, r); check("rst_mask", r, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        // Reset in the middle of a debounce run
        pin = 32'h1;
        repeat (6) step();
        reset = 1'b1;
        #1;
        check("midrst_value", value, 32'h0);
        rd(2'd1, r); check("midrst_rise", r, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        step();
        reset = 1'b0;
        repeat (11) step();
        check("midrst_value_e11", value, 32'h0);
        step();
        check("midrst_value_e12", value, 32'h1);

        pin = '0;
        reset_pulse();

        // Glitch of 8 clk on pin[3] with its interrupt enabled
        bus_write(2'd3, 32'h8);
        irq_hi = 0;
        pin = 32'h8;
        repeat (8) begin step(); if (irq) irq_hi++; end
        pin = 32'h0;
        repeat (20) begin step(); if (irq) irq_hi++; end
        check("glitch_value", value, 32'h0);
        rd(2'd1, r); check("glitch_rise", r, 32'h0);
        rd(2'd2, r); check("glitch_fall", r, 32'h0);
        check("glitch_irq_cycles", irq_hi, 32'd0);

        // Clean press on pin[0]
        bus_write(2'd3, 32'h1);
        pin = 32'h1;
        wait_bit0(1'b1, n);
        check("press_value", value, 32'h1);
        check("press_latency_ok", {31'b0, (n >= 11 && n <= 14)}, 32'h1);
        check("press_irq_same_clk", {31'b0, irq}, 32'h0);
        rd(2'd1, r); check("press_rise", r, 32'h1);
        rd(2'd2, r); check("press_fall", r, 32'h0);
        step();
        check("press_irq_next_clk", {31'b0, irq}, 32'h1);

        // Release, then clear both latches
        pin = 32'h0;
        wait_bit0(1'b0, n);
        check("release_value", value, 32'h0);
        rd(2'd2, r); check("release_fall", r, 32'h1);
        bus_write(2'd1, 32'h1);
        rd(2'd1, r); check("clr_rise", r, 32'h0);
        check("clr_rise_irq", {31'b0, irq}, 32'h1);
        bus_write(2'd2, 32'h1);
        rd(2'd2, r); check("clr_fall", r, 32'h0);
        check("clr_fall_irq_same", {31'b0, irq}, 32'h1);
        step();
        check("clr_fall_irq_next", {31'b0, irq}, 32'h0);

        // Collision: rise[1] sets on the same edge as a W1C of bits 1 and 0.
        // value[0] changes on a tick edge, so ticks follow every 4 clk from here.
        pin = 32'h1;
        wait_bit0(1'b1, n);
        check("coll_pre_value0", value, 32'h1);
        pin = 32'h3;
        repeat (11) step();
        check("coll_pre_value1", value, 32'h1);
        bus_write(2'd1, 32'h3);
        check("coll_value", value, 32'h3);
        rd(2'd1, r); check("coll_rise", r, 32'h2);

        // Several bits at once, mask control, value is read-only
        pin = '0;
        reset_pulse();
        pin = 32'hF000_0001;
        n = 0;
        while (value === 32'h0 && n < 40) begin
            step();
            n++;
        end
        check("multi_value", value, 32'hF000_0001);
        rd(2'd1, r); check("multi_rise", r, 32'hF000_0001);
        rd(2'd2, r); check("multi_fall", r, 32'h0);
        check("multi_irq_masked", {31'b0, irq}, 32'h0);
        repeat (3) step();
        check("multi_irq_masked_later", {31'b0, irq}, 32'h0);
        bus_write(2'd3, 32'h8000_0000);
        check("mask_irq_same", {31'b0, irq}, 32'h0);
        step();
        check("mask_irq_next", {31'b0, irq}, 32'h1);
        bus_write(2'd0, 32'h0);
        check("value_ro", value, 32'hF000_0001);

        // Write without chip select has no effect
        cs   = 1'b0;
        wen  = 1'b1;
        addr = 2'd3;
        din  = 32'h0;
        step();
        wen = 1'b0;
        rd(2'd3, r); check("nocs_mask", r, 32'h8000_0000);
        check("nocs_irq", {31'b0, irq}, 32'h1);

        bus_write(2'd3, 32'h0);
        check("unmask_irq_same", {31'b0, irq}, 32'h1);
        step();
        check("unmask_irq_next", {31'b0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
